// File: rtl/csa_sub_seq.sv
// csa_sub_seq: iterative carry-select subtractor, o_result = A - B mod 2^WIDTH plus unsigned borrow-out.
// Latency: N = ceil(WIDTH/CHUNK) cycles from operand accept to o_valid; one op per N+2 cycles.
// Backpressure: o_ready only in IDLE; result held in DONE until i_ready. Define CSA_SUB_OVF_EN for o_overflow.
module csa_sub_seq #(
  parameter int WIDTH = 29,
  parameter int CHUNK = 4
) (
  input  logic             i_clk,
  input  logic             i_rst,
  input  logic             i_valid,
  output logic             o_ready,
  input  logic [WIDTH-1:0] i_sub_term1,
  input  logic [WIDTH-1:0] i_sub_term2,
  output logic             o_valid,
  input  logic             i_ready,
  output logic [WIDTH-1:0] o_result,
  output logic             o_borrow
`ifdef CSA_SUB_OVF_EN
  ,
  output logic             o_overflow
`endif
);

  // Slice count, width of the (possibly narrower) top slice, padded width, index width.
  localparam int N    = (WIDTH + CHUNK - 1) / CHUNK;
  localparam int LAST = WIDTH - CHUNK * (N - 1);
  localparam int PW   = N * CHUNK;
  localparam int IW   = (N > 1) ? $clog2(N) : 1;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    BUSY = 2'd1,
    DONE = 2'd2
  } state_t;

  state_t                     state_q;
  logic                       ready_q;
  logic                       valid_q;
  logic [WIDTH-1:0]           a_q;
  logic [WIDTH-1:0]           b_q;
  logic [IW-1:0]              idx_q;
  logic                       borrow_q;
  logic [N-1:0][CHUNK-1:0]    acc_q;
  logic [N-1:0][CHUNK-1:0]    acc_d;
  logic [WIDTH-1:0]           result_q;
  logic                       res_borrow_q;
`ifdef CSA_SUB_OVF_EN
  logic                       ovf_q;
`endif

  // Operands viewed as N slices; bits above WIDTH in the top slice read as zero.
  logic [N-1:0][CHUNK-1:0]    a_sl;
  logic [N-1:0][CHUNK-1:0]    b_sl;
  logic [CHUNK-1:0]           a_k;
  logic [CHUNK-1:0]           b_k;
  logic [CHUNK:0]             d0;
  logic [CHUNK:0]             d1;
  logic [CHUNK:0]             sel;
  logic                       is_last;
  logic                       bout;
  logic [PW-1:0]              acc_flat;
  logic [WIDTH-1:0]           diff_full;

  assign a_sl = PW'(a_q);
  assign b_sl = PW'(b_q);
  assign a_k  = a_sl[idx_q];
  assign b_k  = b_sl[idx_q];

  assign is_last = (idx_q == IW'(N - 1));

  // Carry-select slice: both borrow-in candidates computed in parallel, registered borrow picks one.
  always_comb begin
    d0  = {1'b0, a_k} - {1'b0, b_k};
    d1  = {1'b0, a_k} - {1'b0, b_k} - (CHUNK + 1)'(1);
    sel = borrow_q ? d1 : d0;
    // The top slice is only LAST bits wide, so its borrow sits at bit LAST rather than CHUNK.
    if (is_last) begin
      bout = sel[LAST];
    end else begin
      bout = sel[CHUNK];
    end
  end

  // Accumulator with the current slice merged in, so the final edge can load the full difference.
  always_comb begin
    acc_d        = acc_q;
    acc_d[idx_q] = sel[CHUNK-1:0];
  end

  assign acc_flat  = acc_d;
  assign diff_full = WIDTH'(acc_flat);

  // Control FSM with registered handshake and result outputs.
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      state_q      <= IDLE;
      ready_q      <= 1'b1;
      valid_q      <= 1'b0;
      a_q          <= '0;
      b_q          <= '0;
      idx_q        <= '0;
      borrow_q     <= 1'b0;
      acc_q        <= '0;
      result_q     <= '0;
      res_borrow_q <= 1'b0;
`ifdef CSA_SUB_OVF_EN
      ovf_q        <= 1'b0;
`endif
    end else begin
      case (state_q)
        IDLE: begin
          if (i_valid) begin
            a_q      <= i_sub_term1;
            b_q      <= i_sub_term2;
            idx_q    <= '0;
            borrow_q <= 1'b0;
            ready_q  <= 1'b0;
            state_q  <= BUSY;
          end
        end
        BUSY: begin
          acc_q    <= acc_d;
          borrow_q <= bout;
          idx_q    <= idx_q + IW'(1);
          if (is_last) begin
            // Result registers change only here (and on reset), never mid-operation.
            result_q     <= diff_full;
            res_borrow_q <= bout;
`ifdef CSA_SUB_OVF_EN
            ovf_q        <= (a_q[WIDTH-1] != b_q[WIDTH-1]) &&
                            (diff_full[WIDTH-1] != a_q[WIDTH-1]);
`endif
            valid_q      <= 1'b1;
            state_q      <= DONE;
          end
        end
        DONE: begin
          if (i_ready) begin
            valid_q <= 1'b0;
            ready_q <= 1'b1;
            state_q <= IDLE;
          end
        end
        default: begin
          valid_q <= 1'b0;
          ready_q <= 1'b1;
          state_q <= IDLE;
        end
      endcase
    end
  end

  assign o_ready  = ready_q;
  assign o_valid  = valid_q;
  assign o_result = result_q;
  assign o_borrow = res_borrow_q;
`ifdef CSA_SUB_OVF_EN
  assign o_overflow = ovf_q;
`endif

endmodule
